// File: rtl/sweep_pkg.sv
// Shared types and constants for the triangle-sweep sequencer.
// The ST_DWELL state is only reachable when SWEEP_DWELL_EN is defined.
package sweep_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_DWELL = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/sweep_step_counter.sv
// Loadable up/down step counter driven by the sweep sequencer.
// A load takes priority over a step; with neither asserted the value holds.
module sweep_step_counter
  import sweep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] one_s;

  assign one_s = {{(WIDTH-1){1'b0}}, 1'b1};

  // Counter register: load, step in the requested direction, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en) begin
      count_r <= (dir == DIR_UP) ? (count_r + one_s) : (count_r - one_s);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle sweep sequencer between latched lo/hi limits, num_sweeps triangles (0 = endless).
// Define SWEEP_DWELL_EN to hold the count for DWELL extra cycles at every turnaround.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 8
`ifdef SWEEP_DWELL_EN
  ,
  parameter int DWELL   = 2
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   lo_r, lo_s, hi_r, hi_s;
  logic [SWEEP_W-1:0] nsw_r, nsw_s, sweep_r, sweep_s, sweep_inc_s;
  logic               up_down_r, up_down_s;
  logic               busy_r, busy_s, done_r, done_s, err_r, err_s;
  logic               cnt_load_s, cnt_en_s, cnt_dir_s;
  logic [WIDTH-1:0]   cnt_load_val_s;
  logic [WIDTH-1:0]   cnt_s;
`ifdef SWEEP_DWELL_EN
  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
  logic [3:0]         dwell_r, dwell_s;
`endif

  sweep_step_counter #(.WIDTH(WIDTH)) u_step (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .en       (cnt_en_s),
    .dir      (cnt_dir_s),
    .count    (cnt_s)
  );

  assign sweep_inc_s = sweep_r + {{(SWEEP_W-1){1'b0}}, 1'b1};

  // Next-state, counter control and registered-output next values
  always_comb begin
    state_s        = state_r;
    lo_s           = lo_r;
    hi_s           = hi_r;
    nsw_s          = nsw_r;
    sweep_s        = sweep_r;
    up_down_s      = up_down_r;
    busy_s         = busy_r;
    done_s         = 1'b0;
    err_s          = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = lo_r;
    cnt_en_s       = 1'b0;
    cnt_dir_s      = up_down_r;
`ifdef SWEEP_DWELL_EN
    dwell_s        = dwell_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (start) begin
          if (lo < hi) begin
            lo_s           = lo;
            hi_s           = hi;
            nsw_s          = num_sweeps;
            sweep_s        = '0;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = lo;
            up_down_s      = DIR_UP;
            busy_s         = 1'b1;
            state_s        = ST_UP;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_UP: begin
        if (stop) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else if (hold) begin
          state_s = ST_UP;
        end else if (cnt_s == hi_r) begin
          up_down_s = DIR_DOWN;
`ifdef SWEEP_DWELL_EN
          state_s   = ST_DWELL;
          dwell_s   = 4'd0;
`else
          state_s   = ST_DOWN;
          cnt_en_s  = 1'b1;
          cnt_dir_s = DIR_DOWN;
`endif
        end else begin
          cnt_en_s  = 1'b1;
          cnt_dir_s = DIR_UP;
        end
      end
      ST_DOWN: begin
        if (stop) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else if (hold) begin
          state_s = ST_DOWN;
        end else if (cnt_s == lo_r) begin
          // Sweep complete: finish if the target count is reached, else turn around
          sweep_s   = sweep_inc_s;
          up_down_s = DIR_UP;
          if ((nsw_r != '0) && (sweep_inc_s == nsw_r)) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
`ifdef SWEEP_DWELL_EN
            state_s   = ST_DWELL;
            dwell_s   = 4'd0;
`else
            state_s   = ST_UP;
            cnt_en_s  = 1'b1;
            cnt_dir_s = DIR_UP;
`endif
          end
        end else begin
          cnt_en_s  = 1'b1;
          cnt_dir_s = DIR_DOWN;
        end
      end
`ifdef SWEEP_DWELL_EN
      ST_DWELL: begin
        // up_down already points the way out of the turnaround
        if (stop) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else if (hold) begin
          state_s = ST_DWELL;
        end else if (dwell_r == DWELL_LAST) begin
          cnt_en_s  = 1'b1;
          cnt_dir_s = up_down_r;
          state_s   = (up_down_r == DIR_UP) ? ST_UP : ST_DOWN;
        end else begin
          dwell_s = dwell_r + 4'd1;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      lo_r      <= '0;
      hi_r      <= '0;
      nsw_r     <= '0;
      sweep_r   <= '0;
      up_down_r <= DIR_UP;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
`ifdef SWEEP_DWELL_EN
      dwell_r   <= 4'd0;
`endif
    end else begin
      state_r   <= state_s;
      lo_r      <= lo_s;
      hi_r      <= hi_s;
      nsw_r     <= nsw_s;
      sweep_r   <= sweep_s;
      up_down_r <= up_down_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
`ifdef SWEEP_DWELL_EN
      dwell_r   <= dwell_s;
`endif
    end
  end

  assign count   = cnt_s;
  assign up_down = up_down_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: a waveform-queue reference model checked every cycle,
// a table of start requests, hand-written corner sequences and a randomized phase.
module tb_sweep_ctrl;

  localparam int WIDTH   = 4;
  localparam int SWEEP_W = 8;
`ifdef SWEEP_DWELL_EN
  localparam int TB_DWELL = 2;
`else
  localparam int TB_DWELL = 0;
`endif

  logic               clk = 1'b0;
  logic               rst, start, stop, hold;
  logic [WIDTH-1:0]   lo, hi;
  logic [SWEEP_W-1:0] num_sweeps;
  logic [WIDTH-1:0]   count;
  logic               up_down, busy, done, err;

  sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .lo         (lo),
    .hi         (hi),
    .num_sweeps (num_sweeps),
    .count      (count),
    .up_down    (up_down),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected output waveform of a run is laid out in a queue
  typedef struct {int cnt; bit ud; bit bsy; bit dn;} rec_t;
  rec_t q[$];
  int   m_count = 0, m_lo = 0, m_hi = 0;
  bit   m_ud = 1'b1, m_ud_valid = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_inf = 1'b0;

  function automatic void push_rec(int c, bit u, bit b, bit d);
    rec_t r;
    r.cnt = c; r.ud = u; r.bsy = b; r.dn = d;
    q.push_back(r);
  endfunction

  // One triangle that starts just after a visible lo and ends on lo
  function automatic void push_triangle(bit last);
    for (int v = m_lo + 1; v <= m_hi; v++) push_rec(v, 1'b1, 1'b1, 1'b0);
    for (int d = 0; d < TB_DWELL; d++) push_rec(m_hi, 1'b0, 1'b1, 1'b0);
    for (int v = m_hi - 1; v >= m_lo; v--) push_rec(v, 1'b0, 1'b1, 1'b0);
    if (last) push_rec(m_lo, 1'b1, 1'b0, 1'b1);
    else for (int d = 0; d < TB_DWELL; d++) push_rec(m_lo, 1'b1, 1'b1, 1'b0);
  endfunction

  always @(posedge clk) begin
    rec_t r;
    if (rst) begin
      q.delete();
      m_count = 0; m_ud = 1'b1; m_ud_valid = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_inf = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_busy) begin
        if (stop) begin
          q.delete();
          m_busy = 1'b0; m_inf = 1'b0; m_ud_valid = 1'b0;
        end else if (!hold) begin
          if (m_inf && q.size() < 40) push_triangle(1'b0);
          r = q.pop_front();
          m_count = r.cnt; m_ud = r.ud; m_busy = r.bsy; m_done = r.dn;
        end
      end else if (!stop && start) begin
        if (lo < hi) begin
          m_lo = int'(lo); m_hi = int'(hi);
          m_count = m_lo; m_ud = 1'b1; m_ud_valid = 1'b1; m_busy = 1'b1;
          m_inf = (num_sweeps == '0);
          if (m_inf) push_triangle(1'b0);
          else for (int i = 0; i < int'(num_sweeps); i++) push_triangle(i == int'(num_sweeps) - 1);
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", 32'(count), 32'(m_count));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_err", 32'(err), 32'(m_err));
      chk("done_err_excl", 32'(done & err), 32'd0);
      if (m_ud_valid) chk("model_up_down", 32'(up_down), 32'(m_ud));
    end
  end

  task automatic wait_count(input int v, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (int'(count) == v) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic run_seq(input string name, input int n, input int exp_c[], input bit exp_u[]);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      chk({name, "_count"}, 32'(count), 32'(exp_c[k]));
      chk({name, "_up_down"}, 32'(up_down), 32'(exp_u[k]));
      chk({name, "_busy"}, 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_final_count"}, 32'(count), 32'(exp_c[n-1]));
    @(negedge clk);
    chk({name, "_done_clear"}, 32'(done), 32'd0);
  endtask

  typedef struct {int lo; int hi; int n; bit err; int done_k;} vec_t;
  vec_t tbl[7];

  initial begin
    int prev, k, expk;
    int ec[];
    bit eu[];
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
    lo = '0; hi = '0; num_sweeps = '0;
    tbl[0] = '{lo: 7,  hi: 7,  n: 0, err: 1'b1, done_k: 0};
    tbl[1] = '{lo: 9,  hi: 3,  n: 0, err: 1'b1, done_k: 0};
    tbl[2] = '{lo: 15, hi: 0,  n: 1, err: 1'b1, done_k: 0};
    tbl[3] = '{lo: 2,  hi: 5,  n: 2, err: 1'b0, done_k: 13};
    tbl[4] = '{lo: 14, hi: 15, n: 1, err: 1'b0, done_k: 3};
    tbl[5] = '{lo: 0,  hi: 15, n: 1, err: 1'b0, done_k: 31};
    tbl[6] = '{lo: 3,  hi: 10, n: 3, err: 1'b0, done_k: 43};

    repeat (3) @(negedge clk);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_up_down", 32'(up_down), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

`ifndef SWEEP_DWELL_EN
    // Basic run; limit changes and a start pulse while busy must be ignored
    lo = 4'd2; hi = 4'd5; num_sweeps = 8'd2; start = 1'b1;
    fork
      begin
        @(negedge clk); @(negedge clk);
        lo = 4'd0; hi = 4'd15; num_sweeps = 8'd0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join_none
    ec = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
    eu = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    run_seq("basic", 13, ec, eu);
    // Restart after done: the sweep counter begins again from zero
    lo = 4'd0; hi = 4'd1; num_sweeps = 8'd3; start = 1'b1;
    ec = '{0, 1, 0, 1, 0, 1, 0};
    eu = '{1, 1, 0, 1, 0, 1, 0};
    run_seq("restart", 7, ec, eu);
`else
    lo = 4'd2; hi = 4'd4; num_sweeps = 8'd1; start = 1'b1;
    ec = '{2, 3, 4, 4, 4, 3, 2};
    eu = '{1, 1, 1, 0, 0, 0, 0};
    run_seq("dwell", 7, ec, eu);
`endif

    // Table of start requests: error pulses and done latency
    foreach (tbl[i]) begin
      @(negedge clk);
      prev = int'(count);
      lo = 4'(tbl[i].lo); hi = 4'(tbl[i].hi); num_sweeps = 8'(tbl[i].n); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("tbl_err", 32'(err), 32'(tbl[i].err));
      if (tbl[i].err) begin
        chk("tbl_err_busy", 32'(busy), 32'd0);
        chk("tbl_err_count", 32'(count), 32'(prev));
        @(negedge clk);
        chk("tbl_err_clear", 32'(err), 32'd0);
      end else begin
        chk("tbl_first_count", 32'(count), 32'(tbl[i].lo));
        k = 0;
        while (!done && k < 200) begin
          @(negedge clk);
          k++;
        end
        expk = tbl[i].done_k + TB_DWELL * (2 * tbl[i].n - 1);
        chk("tbl_done_latency", 32'(k), 32'(expk));
        chk("tbl_done_count", 32'(count), 32'(tbl[i].lo));
      end
    end

    // Hold at 6 for three cycles, then stop at 9
    @(negedge clk);
    lo = 4'd0; hi = 4'd15; num_sweeps = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_count(6, "hold_reach6");
    hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_count", 32'(count), 32'd6);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold_release", 32'(count), 32'd7);
    wait_count(9, "stop_reach9");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    chk("stop_count", 32'(count), 32'd9);
    @(negedge clk);
    chk("stop_idle_count", 32'(count), 32'd9);

    // Start together with stop in IDLE does nothing
    lo = 4'd1; hi = 4'd4; num_sweeps = 8'd0; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("conflict_busy", 32'(busy), 32'd0);
    chk("conflict_err", 32'(err), 32'd0);
    chk("conflict_count", 32'(count), 32'd9);

    // Reset in the middle of a sweep
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_count(3, "rst_reach3");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_up_down", 32'(up_down), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 299) == 0);
      stop       = ($urandom_range(0, 39) == 0);
      hold       = ($urandom_range(0, 7) == 0);
      start      = ($urandom_range(0, 5) == 0);
      lo         = 4'($urandom_range(0, 15));
      hi         = 4'($urandom_range(0, 15));
      num_sweeps = 8'($urandom_range(0, 3));
    end
    rst = 1'b0; stop = 1'b0; hold = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
